// File: rtl/reg_file_wb_pkg.sv
// Shared sizing for the writeback-side register file and its pending-write scoreboard.
package reg_file_wb_pkg;

    localparam int WORD_WIDTH           = 32;
    localparam int REG_FILE_ADDRESS_LEN = 4;
    localparam int REG_FILE_SIZE        = 16;
    localparam int PEND_WIDTH           = 2;

    // Largest number of writes that may be in flight to one register.
    localparam logic [PEND_WIDTH-1:0] PEND_MAX = PEND_WIDTH'((1 << PEND_WIDTH) - 1);

endpackage

// File: rtl/reg_file_wb_pend_counter.sv
// Saturating up/down counter tracking in-flight writes to one register.
// Counting up past PEND_MAX holds the value and pulses sat_hit; counting
// down at zero holds at zero. Simultaneous inc and dec cancel.
module pend_counter
    import reg_file_wb_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inc,
    input  logic                  dec,
    output logic [PEND_WIDTH-1:0] count,
    output logic                  is_zero,
    output logic                  is_one,
    output logic                  sat_hit
);

    logic [PEND_WIDTH-1:0] r_count;

    // Count update: reset wins, then one-sided inc or dec within bounds.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (inc && !dec && r_count != PEND_MAX) begin
            r_count <= r_count + 1'b1;
        end else if (dec && !inc && r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign count   = r_count;
    assign is_zero = (r_count == '0);
    assign is_one  = (r_count == PEND_WIDTH'(1));
    assign sat_hit = inc && !dec && (r_count == PEND_MAX);

endmodule

// File: rtl/reg_file_wb.sv
// 16 x 32 architectural register file written from the writeback stage,
// with two bypassed decode read ports and a per-register pending-write
// scoreboard that flags read-after-write hazards.
// Handshake: WB_en is a valid-only strobe (no back-pressure); issue_en is
// accepted only when hazard is low, otherwise decode must re-present it.
module reg_file_wb
    import reg_file_wb_pkg::*;
(
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            WB_en,
    input  logic [REG_FILE_ADDRESS_LEN-1:0] WB_dst,
    input  logic [WORD_WIDTH-1:0]           WB_value,
    input  logic [REG_FILE_ADDRESS_LEN-1:0] src1,
    input  logic [REG_FILE_ADDRESS_LEN-1:0] src2,
    input  logic                            two_src,
    input  logic                            issue_en,
    input  logic [REG_FILE_ADDRESS_LEN-1:0] issue_dst,
    output logic [WORD_WIDTH-1:0]           val_Rn,
    output logic [WORD_WIDTH-1:0]           val_Rm,
    output logic                            hazard,
    output logic                            pend_overflow
);

    logic [WORD_WIDTH-1:0]    r_regs [REG_FILE_SIZE];
    logic                     r_pend_overflow;

    logic [PEND_WIDTH-1:0]    w_count [REG_FILE_SIZE];
    logic [REG_FILE_SIZE-1:0] w_inc;
    logic [REG_FILE_SIZE-1:0] w_dec;
    logic [REG_FILE_SIZE-1:0] w_is_zero;
    logic [REG_FILE_SIZE-1:0] w_is_one;
    logic [REG_FILE_SIZE-1:0] w_sat_hit;
    logic                     w_h1;
    logic                     w_h2;

    // Register array: clear on reset, otherwise commit the writeback.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_FILE_SIZE; i++) begin
                r_regs[i] <= '0;
            end
        end else if (WB_en) begin
            r_regs[WB_dst] <= WB_value;
        end
    end

    // Sticky overflow flag: set when any pending counter would exceed its max.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend_overflow <= 1'b0;
        end else if (|w_sat_hit) begin
            r_pend_overflow <= 1'b1;
        end
    end

    // One scoreboard counter per register; stalled issues do not count.
    for (genvar g = 0; g < REG_FILE_SIZE; g++) begin : g_pend
        assign w_inc[g] = issue_en && (issue_dst == REG_FILE_ADDRESS_LEN'(g)) && !hazard;
        assign w_dec[g] = WB_en && (WB_dst == REG_FILE_ADDRESS_LEN'(g));

        pend_counter u_pend (
            .clk     (clk),
            .rst     (rst),
            .inc     (w_inc[g]),
            .dec     (w_dec[g]),
            .count   (w_count[g]),
            .is_zero (w_is_zero[g]),
            .is_one  (w_is_one[g]),
            .sat_hit (w_sat_hit[g])
        );

        a_zero_consistent: assert property (@(posedge clk) w_is_zero[g] == (w_count[g] == '0));
    end

    // A pending write resolving in this very cycle (last one, bypassed) is not a hazard.
    assign w_h1 = !w_is_zero[src1] && !(w_is_one[src1] && WB_en && WB_dst == src1);
    assign w_h2 = two_src && !w_is_zero[src2] && !(w_is_one[src2] && WB_en && WB_dst == src2);
    assign hazard = w_h1 | w_h2;

    // Read ports with same-cycle writeback bypass.
    assign val_Rn = (WB_en && WB_dst == src1) ? WB_value : r_regs[src1];
    assign val_Rm = (WB_en && WB_dst == src2) ? WB_value : r_regs[src2];

    assign pend_overflow = r_pend_overflow;

endmodule

// File: tb/tb_reg_file_wb.sv
// Bench for reg_file_wb: directed scenarios plus random traffic, all checked
// against an array-based model of registers, pending counts and overflow.
module tb_reg_file_wb;

    logic        clk = 1'b0;
    logic        rst;
    logic        WB_en;
    logic [3:0]  WB_dst;
    logic [31:0] WB_value;
    logic [3:0]  src1;
    logic [3:0]  src2;
    logic        two_src;
    logic        issue_en;
    logic [3:0]  issue_dst;
    logic [31:0] val_Rn;
    logic [31:0] val_Rm;
    logic        hazard;
    logic        pend_overflow;

    int          n_checks = 0;
    int          n_fail   = 0;

    // Reference model state
    logic [31:0] m_regs [16];
    int          m_pend [16];
    logic        m_ovf;

    reg_file_wb dut (
        .clk           (clk),
        .rst           (rst),
        .WB_en         (WB_en),
        .WB_dst        (WB_dst),
        .WB_value      (WB_value),
        .src1          (src1),
        .src2          (src2),
        .two_src       (two_src),
        .issue_en      (issue_en),
        .issue_dst     (issue_dst),
        .val_Rn        (val_Rn),
        .val_Rm        (val_Rm),
        .hazard        (hazard),
        .pend_overflow (pend_overflow)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [3:0] a);
        return (WB_en && WB_dst == a) ? WB_value : m_regs[a];
    endfunction

    function automatic logic m_src_busy(input logic [3:0] a);
        // Outstanding writes, unless the only one completes right now.
        return (m_pend[a] > 0) && !(m_pend[a] == 1 && WB_en && WB_dst == a);
    endfunction

    function automatic logic m_hazard();
        return m_src_busy(src1) || (two_src && m_src_busy(src2));
    endfunction

    task automatic drive(input logic r, input logic we, input logic [3:0] wd, input logic [31:0] wv,
                         input logic [3:0] s1, input logic [3:0] s2, input logic two,
                         input logic ie, input logic [3:0] id);
        rst = r; WB_en = we; WB_dst = wd; WB_value = wv;
        src1 = s1; src2 = s2; two_src = two; issue_en = ie; issue_dst = id;
    endtask

    // Compare combinational outputs with the model for the current inputs.
    task automatic settle_check();
        #1;
        check("val_Rn", val_Rn, m_read(src1));
        check("val_Rm", val_Rm, m_read(src2));
        check("hazard", {31'b0, hazard}, {31'b0, m_hazard()});
        check("pend_overflow", {31'b0, pend_overflow}, {31'b0, m_ovf});
    endtask

    // Advance one clock and apply the same inputs to the model.
    task automatic tick();
        logic hz;
        hz = m_hazard();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                m_regs[i] = '0;
                m_pend[i] = 0;
            end
            m_ovf = 1'b0;
        end else begin
            if (issue_en && !hz && !(WB_en && WB_dst == issue_dst)) begin
                if (m_pend[issue_dst] == 3) m_ovf = 1'b1;
                else m_pend[issue_dst]++;
            end
            if (WB_en && !(issue_en && !hz && issue_dst == WB_dst)) begin
                if (m_pend[WB_dst] > 0) m_pend[WB_dst]--;
            end
            if (WB_en) m_regs[WB_dst] = WB_value;
        end
        @(negedge clk);
    endtask

    initial begin
        drive(1, 0, 0, 0, 3, 7, 1, 0, 0);
        @(negedge clk);

        // Reset then read
        tick();
        tick();
        drive(0, 0, 0, 0, 3, 7, 1, 0, 0);
        settle_check();
        check("rst_Rn", val_Rn, 32'h0);
        check("rst_Rm", val_Rm, 32'h0);
        check("rst_hazard", {31'b0, hazard}, 32'h0);
        check("rst_ovf", {31'b0, pend_overflow}, 32'h0);
        tick();

        // Write with bypass, then read from the array
        drive(0, 1, 5, 32'hDEADBEEF, 5, 0, 0, 0, 0);
        settle_check();
        check("bypass_Rn", val_Rn, 32'hDEADBEEF);
        tick();
        drive(0, 0, 0, 0, 5, 5, 0, 0, 0);
        settle_check();
        check("stored_Rn", val_Rn, 32'hDEADBEEF);
        check("stored_Rm", val_Rm, 32'hDEADBEEF);
        tick();

        // Hazard lifecycle on R2
        drive(0, 0, 0, 0, 0, 0, 0, 1, 2);
        settle_check();
        tick();
        drive(0, 0, 0, 0, 2, 0, 0, 0, 0);
        settle_check();
        check("haz_r2_set", {31'b0, hazard}, 32'h1);
        tick();
        drive(0, 1, 2, 32'h11, 2, 0, 0, 0, 0);
        settle_check();
        check("haz_r2_wb", {31'b0, hazard}, 32'h0);
        check("haz_r2_val", val_Rn, 32'h11);
        tick();
        drive(0, 0, 0, 0, 2, 0, 0, 0, 0);
        settle_check();
        check("haz_r2_clear", {31'b0, hazard}, 32'h0);
        tick();

        // Two in flight on R4, then a simultaneous issue + writeback
        repeat (2) begin
            drive(0, 0, 0, 0, 0, 0, 0, 1, 4);
            settle_check();
            tick();
        end
        drive(0, 1, 4, 32'h44, 0, 0, 0, 1, 4);
        settle_check();
        tick();
        drive(0, 0, 0, 0, 4, 0, 0, 0, 0);
        settle_check();
        check("r4_still_pending", {31'b0, hazard}, 32'h1);
        tick();
        drive(0, 1, 4, 32'h45, 4, 0, 0, 0, 0);
        settle_check();
        check("r4_pend2_wb", {31'b0, hazard}, 32'h1);
        tick();
        drive(0, 1, 4, 32'h46, 4, 0, 0, 0, 0);
        settle_check();
        check("r4_last_wb", {31'b0, hazard}, 32'h0);
        tick();
        drive(0, 0, 0, 0, 4, 0, 0, 0, 0);
        settle_check();
        check("r4_drained", {31'b0, hazard}, 32'h0);
        tick();

        // Saturation on R9
        repeat (4) begin
            drive(0, 0, 0, 0, 0, 0, 0, 1, 9);
            settle_check();
            tick();
        end
        drive(0, 0, 0, 0, 9, 0, 0, 0, 0);
        settle_check();
        check("ovf_set", {31'b0, pend_overflow}, 32'h1);
        check("r9_hazard", {31'b0, hazard}, 32'h1);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        settle_check();
        check("ovf_sticky", {31'b0, pend_overflow}, 32'h1);

        // Writeback to an idle register underflows harmlessly
        drive(0, 1, 1, 32'hA5A5_0001, 0, 0, 0, 0, 0);
        settle_check();
        tick();
        drive(0, 0, 0, 0, 1, 0, 0, 0, 0);
        settle_check();
        check("r1_written", val_Rn, 32'hA5A5_0001);
        check("r1_no_hazard", {31'b0, hazard}, 32'h0);
        tick();

        // Reset in the middle of activity on R6
        drive(0, 1, 6, 32'h55, 0, 0, 0, 0, 0);
        tick();
        repeat (2) begin
            drive(0, 0, 0, 0, 0, 0, 0, 1, 6);
            tick();
        end
        drive(1, 1, 6, 32'h77, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 6, 6, 1, 0, 0);
        settle_check();
        check("mid_rst_r6", val_Rn, 32'h0);
        check("mid_rst_hazard", {31'b0, hazard}, 32'h0);
        check("mid_rst_ovf", {31'b0, pend_overflow}, 32'h0);
        tick();

        // src2 hazard gated by two_src
        drive(0, 0, 0, 0, 0, 0, 0, 1, 8);
        tick();
        drive(0, 0, 0, 0, 0, 8, 0, 0, 0);
        settle_check();
        check("src2_gated", {31'b0, hazard}, 32'h0);
        drive(0, 0, 0, 0, 0, 8, 1, 0, 0);
        settle_check();
        check("src2_used", {31'b0, hazard}, 32'h1);
        tick();

        // Random traffic over a narrow register window to provoke collisions
        for (int n = 0; n < 600; n++) begin
            drive(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 45),
                  4'($urandom_range(0, 5)), $urandom,
                  4'($urandom_range(0, 5)), 4'($urandom_range(0, 5)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 99) < 40), 4'($urandom_range(0, 5)));
            if (n % 97 == 0) src1 = 4'd15;
            settle_check();
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
